// File: rtl/bsg_ddr_capture_buf.sv
// Circular register-file FIFO with read/write pointers and an occupancy count.
// Latency: a word written at a posedge is readable on data_o right after that edge.
// Backpressure: the caller must gate enq_i on full_o (or a same-edge deq_i); full_o reports it.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_ddr_capture_buf #(
  parameter int width_p = -1,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               full_o
);

  localparam int ptr_width_lp = `BSG_SAFE_CLOG2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_cnt_lp  = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;

  // Storage write; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq_i) mem_r[wr_ptr_r] <= data_i;
  end

  // Pointers wrap at els_p (depth need not be a power of two); count separates full from empty.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq_i) wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
      if (deq_i) rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
      if (enq_i && !deq_i)      count_r <= count_r + 1'b1;
      else if (!enq_i && deq_i) count_r <= count_r - 1'b1;
    end
  end

  assign data_o = mem_r[rd_ptr_r];
  assign v_o    = (count_r != '0);
  assign full_o = (count_r == els_cnt_lp);

endmodule

// File: rtl/bsg_dff_negedge_reset.sv
// Falling-edge register with synchronous active-high clear (clear sampled on the falling edge).
// Latency: output updates at each negedge of clk_i.
// Backpressure: none; captures every falling edge unconditionally.
module bsg_dff_negedge_reset #(
  parameter int width_p = -1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_r;

  // Capture on the falling edge; reset wins over data.
  always_ff @(negedge clk_i) begin
    if (reset_i) data_r <= '0;
    else         data_r <= data_i;
  end

  assign data_o = data_r;

endmodule

// File: rtl/bsg_ddr_capture_sipo.sv
// DDR capture: negedge beat + following posedge beat assembled into {pos, neg} words, queued els_p deep.
// Latency: one cycle from the capturing posedge to data_o/v_o.
// Backpressure: none upstream; pairs arriving to a full buffer (no same-edge yumi) are dropped and counted.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_ddr_capture_sipo #(
  parameter int width_p          = -1,
  parameter int els_p            = 2,
  parameter int drop_cnt_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [width_p-1:0]          data_i,
  input  logic                        v_i,
  output logic [2*width_p-1:0]        data_o,
  output logic                        v_o,
  input  logic                        yumi_i,
  output logic                        overflow_o,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o
);

  logic [width_p-1:0]          lo_beat;
  logic                        lo_ok;
  logic                        full;
  logic                        deq, enq, drop;
  logic                        overflow_r;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;

  bsg_dff_negedge_reset #(.width_p(width_p)) lo_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .data_o  (lo_beat)
  );

  // Marks that the held low beat was captured out of reset, so no pair
  // straddling reset release can be accepted.
  bsg_dff_negedge_reset #(.width_p(1)) lo_ok_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (1'b1),
    .data_o  (lo_ok)
  );

  assign deq  = yumi_i & v_o;
  assign enq  = v_i & lo_ok & ~reset_i & (~full | deq);
  assign drop = v_i & lo_ok & ~reset_i & full & ~deq;

  bsg_ddr_capture_buf #(.width_p(2*width_p), .els_p(els_p)) buf_inst (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (enq),
    .data_i  ({data_i, lo_beat}),
    .deq_i   (deq),
    .data_o  (data_o),
    .v_o     (v_o),
    .full_o  (full)
  );

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else if (drop) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + 1'b1;
    end
  end

  assign overflow_o = overflow_r;
  assign drop_cnt_o = drop_cnt_r;

  yumi_on_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule
